cpu_clk_ctrl: RTL and testbench
===============================

Name: cpu_clk_ctrl

Overview:
- Sits directly downstream of slow_clk.
- Turns its slow_clk level output into single-cycle clock-enable pulses (cpu_en) for the pipelined RISC-V core, which runs on the fast board clk.
- Three modes: free-run at the slow_clk rate, single-step by debounced push-button, and halt on a core request.
- Also counts retired enable pulses for display/debug.

Parameters:
- DEB_SAMPLES, 4, number of consecutive slow_clk rising edges step_btn must be stable before its debounced level changes (legal range 2..15).
- CNT_W, 32, width of cycle_cnt.

Ports:
- clk  in  1  board clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- slow_clk  in  1  output of slow_clk; treated as an asynchronous level and synchronized internally.
- run_sw  in  1  asynchronous switch: 1 = RUN mode, 0 = STEP mode.
- step_btn  in  1  asynchronous, bouncy push-button.
- halt_req  in  1  synchronous to clk, from core (ecall/ebreak retire).
- cpu_en  out  1  one-cycle enable pulse to core pipeline registers.
- mode  out  2  00 = STEP, 01 = RUN, 10 = HALT; 11 is never driven.
- halted  out  1  1 while mode = HALT.
- cycle_cnt  out  CNT_W  number of cpu_en pulses issued since reset.

Behaviour:
- Clock/reset: one clock, clk; rst synchronous, active-high.
- Reset values:
  - cpu_en = 0, mode = STEP (00), halted = 0, cycle_cnt = 0.
  - All synchronizer and edge flops = 0; debounced level = 0; debounce counter = 0.
  - Reset asserted mid-operation behaves identically.
  - cpu_en is 0 in the cycle after any cycle in which rst = 1.
- Synchronization:
  - slow_clk, run_sw and step_btn each pass through a 2-flop synchronizer.
  - slow_tick = sync_slow & ~prev_slow, which is one clk cycle wide per slow_clk rising edge.
- Mode FSM:
  - STEP -> RUN when synced run_sw = 1.
  - RUN -> STEP when synced run_sw = 0.
  - STEP or RUN -> HALT when halt_req = 1 at a clk edge.
  - HALT is left only by rst; run_sw and step_btn are ignored in HALT.
  - mode and halted are registered and update one clk after the cause.
- RUN mode:
  - cpu_en = 1 for exactly one cycle per slow_clk rising edge.
  - Latency: slow_clk is first sampled high at edge N; cpu_en is high during the cycle after edge N+3 (2 sync + 1 edge-detect + 1 output register).
- Debounce:
  - Evaluated only on slow_tick cycles.
  - If synced step_btn differs from the debounced level, the counter increments; otherwise it clears.
  - When the counter reaches DEB_SAMPLES, the debounced level takes the new value and the counter clears.
  - A glitch shorter than DEB_SAMPLES ticks produces no change.
- STEP mode:
  - A 0->1 change of the debounced level produces cpu_en = 1 for exactly one cycle, on the clk after the change.
  - Button releases produce nothing.
  - Debounced presses made in RUN or HALT mode are discarded, not queued.
- Halt priority: if halt_req = 1 in the same cycle a cpu_en would be registered, cpu_en stays 0 and the mode goes to HALT.
- cycle_cnt:
  - Increments in the cycle after each cpu_en = 1.
  - Saturates at all-ones; never wraps.
- Mode switch at a tick: the RUN/STEP decision uses the registered mode at the cycle the enable is computed. There is never more than one cpu_en per slow_tick.

Test Plan:
- Reset then RUN: rst for 2 clk; run_sw = 1; slow_clk toggles every 8 clk for 5 rising edges -> exactly 5 one-cycle cpu_en pulses, each 4 clk after the rising edge; cycle_cnt = 5; mode = 01.
- STEP debounce: run_sw = 0, DEB_SAMPLES = 4; step_btn high for 2 ticks, low, then high for 6 ticks, then low for 6 ticks -> exactly 1 cpu_en pulse (after the 4th stable tick); none on release; cycle_cnt = 1.
- Halt priority: RUN mode; assert halt_req in the same cycle a cpu_en would be registered -> cpu_en stays 0, mode = 10, halted = 1 next cycle; 10 further slow ticks and button presses -> no cpu_en; cycle_cnt frozen.
- Reset mid-halt: from HALT, rst = 1 for 1 cycle -> mode = 00, halted = 0, cycle_cnt = 0, cpu_en = 0; a subsequent debounced press yields 1 pulse.
- Mode switch: in RUN, drop run_sw between ticks -> pulses stop within 3 clk of the switch change; a press made while in RUN is not replayed after entering STEP.
- Saturation: CNT_W = 3, RUN mode, 10 slow ticks -> cycle_cnt reaches 7 and holds at 7.

Source files
------------

// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: turns the slow_clk level into one-cycle clock-enable pulses
// for the RISC-V core, which runs on the fast board clock.
//
// There are three modes:
//   STEP : one pulse per debounced press of step_btn.
//   RUN  : one pulse per rising edge of slow_clk.
//   HALT : no pulses. Entered on halt_req and left only by rst.
//
// Ports:
//   clk       in   board clock; all state changes on its rising edge
//   rst       in   synchronous, active-high reset
//   slow_clk  in   slow clock level (asynchronous, synchronized here)
//   run_sw    in   asynchronous switch, 1 = RUN, 0 = STEP
//   step_btn  in   asynchronous bouncy push-button
//   halt_req  in   synchronous halt request from the core
//   cpu_en    out  one-cycle enable for the core pipeline registers
//   mode      out  00 = STEP, 01 = RUN, 10 = HALT (the FSM state itself)
//   halted    out  1 while mode = HALT
//   cycle_cnt out  saturating count of cpu_en pulses since reset
//
// Handshake: none. cpu_en is a plain registered strobe with no back-pressure.
// Each cpu_en = 1 cycle means one core step has been issued.
module cpu_clk_ctrl #(
  parameter int DEB_SAMPLES = 4,  // legal range 2..15
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             slow_clk,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             halt_req,
  output logic             cpu_en,
  output logic [1:0]       mode,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    MODE_STEP = 2'b00,
    MODE_RUN  = 2'b01,
    MODE_HALT = 2'b10
  } mode_e;

  localparam int DEB_W = 4;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_SAMPLES);

  // Two-flop synchronizers
  logic slow_s1_q, slow_s1_d, slow_s2_q, slow_s2_d;
  logic run_s1_q,  run_s1_d,  run_s2_q,  run_s2_d;
  logic btn_s1_q,  btn_s1_d,  btn_s2_q,  btn_s2_d;

  // Edge detection of the synchronized slow clock
  logic prev_slow_q, prev_slow_d;
  logic tick_q, tick_d;

  // Debouncer
  logic             deb_level_q, deb_level_d;
  logic             deb_prev_q,  deb_prev_d;
  logic [DEB_W-1:0] deb_cnt_q,   deb_cnt_d;
  logic [DEB_W-1:0] deb_cnt_inc;
  logic             press;

  // Mode FSM and outputs
  mode_e            mode_q, mode_d;
  logic             halted_q, halted_d;
  logic             cpu_en_q, cpu_en_d;
  logic             en_req;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;

  always_comb begin
    slow_s1_d   = slow_clk;
    slow_s2_d   = slow_s1_q;
    run_s1_d    = run_sw;
    run_s2_d    = run_s1_q;
    btn_s1_d    = step_btn;
    btn_s2_d    = btn_s1_q;
    prev_slow_d = slow_s2_q;

    // The tick is registered. This adds one cycle of latency,
    // so cpu_en appears 4 clk after slow_clk is first sampled high.
    tick_d = slow_s2_q & ~prev_slow_q;

    // The debouncer advances only on slow ticks. The slow_clk period
    // therefore sets the debounce time.
    deb_level_d = deb_level_q;
    deb_cnt_d   = deb_cnt_q;
    deb_cnt_inc = deb_cnt_q + DEB_W'(1);
    if (tick_q) begin
      if (btn_s2_q != deb_level_q) begin
        if (deb_cnt_inc == DEB_LAST) begin
          deb_level_d = btn_s2_q;
          deb_cnt_d   = '0;
        end else begin
          deb_cnt_d = deb_cnt_inc;
        end
      end else begin
        deb_cnt_d = '0;
      end
    end

    // deb_prev tracks the level in every mode. A press debounced while in
    // RUN or HALT is consumed there and never replayed later in STEP.
    deb_prev_d = deb_level_q;
    press      = deb_level_q & ~deb_prev_q;

    mode_d = mode_q;
    case (mode_q)
      MODE_STEP, MODE_RUN: begin
        if (halt_req)      mode_d = MODE_HALT;
        else if (run_s2_q) mode_d = MODE_RUN;
        else               mode_d = MODE_STEP;
      end
      MODE_HALT: mode_d = MODE_HALT;
      default:   mode_d = MODE_STEP;
    endcase
    halted_d = (mode_d == MODE_HALT);

    // The registered mode picks the enable source. A halt request in the
    // same cycle suppresses the enable.
    en_req   = ((mode_q == MODE_RUN)  && tick_q) ||
               ((mode_q == MODE_STEP) && press);
    cpu_en_d = en_req && !halt_req;

    cycle_cnt_d = cycle_cnt_q;
    if (cpu_en_q && (cycle_cnt_q != {CNT_W{1'b1}})) begin
      cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slow_s1_q   <= 1'b0;
      slow_s2_q   <= 1'b0;
      run_s1_q    <= 1'b0;
      run_s2_q    <= 1'b0;
      btn_s1_q    <= 1'b0;
      btn_s2_q    <= 1'b0;
      prev_slow_q <= 1'b0;
      tick_q      <= 1'b0;
      deb_level_q <= 1'b0;
      deb_prev_q  <= 1'b0;
      deb_cnt_q   <= '0;
      mode_q      <= MODE_STEP;
      halted_q    <= 1'b0;
      cpu_en_q    <= 1'b0;
      cycle_cnt_q <= '0;
    end else begin
      slow_s1_q   <= slow_s1_d;
      slow_s2_q   <= slow_s2_d;
      run_s1_q    <= run_s1_d;
      run_s2_q    <= run_s2_d;
      btn_s1_q    <= btn_s1_d;
      btn_s2_q    <= btn_s2_d;
      prev_slow_q <= prev_slow_d;
      tick_q      <= tick_d;
      deb_level_q <= deb_level_d;
      deb_prev_q  <= deb_prev_d;
      deb_cnt_q   <= deb_cnt_d;
      mode_q      <= mode_d;
      halted_q    <= halted_d;
      cpu_en_q    <= cpu_en_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign cpu_en    = cpu_en_q;
  assign mode      = mode_q;
  assign halted    = halted_q;
  assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Bench for cpu_clk_ctrl.
// It drives slow_clk periods, the button, switch changes and halt requests
// with random timing. A tick-level model predicts the clk cycle of every
// cpu_en pulse. A second instance with a 3-bit counter covers saturation.
module tb_cpu_clk_ctrl;
  localparam int DEB = 4;
  localparam int CW  = 32;
  localparam int M_STEP = 0, M_RUN = 1, M_HALT = 2;

  logic clk = 1'b0;
  logic rst, slow_clk, run_sw, step_btn, halt_req;
  logic cpu_en, halted, cpu_en_s, halted_s;
  logic [1:0] mode, mode_s;
  logic [CW-1:0] cycle_cnt;
  logic [2:0] cycle_cnt_s;

  cpu_clk_ctrl #(.DEB_SAMPLES(DEB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .slow_clk(slow_clk), .run_sw(run_sw),
    .step_btn(step_btn), .halt_req(halt_req), .cpu_en(cpu_en),
    .mode(mode), .halted(halted), .cycle_cnt(cycle_cnt));

  cpu_clk_ctrl #(.DEB_SAMPLES(DEB), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .slow_clk(slow_clk), .run_sw(run_sw),
    .step_btn(step_btn), .halt_req(halt_req), .cpu_en(cpu_en_s),
    .mode(mode_s), .halted(halted_s), .cycle_cnt(cycle_cnt_s));

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];   // predicted pulse cycles
  logic [31:0] got_q[$];   // observed pulse cycles
  int checks = 0, failures = 0;
  int m_mode = M_STEP;
  bit m_level = 1'b0;
  bit samp_q[$];           // tick samples since the last level change
  int exp_total = 0;

  always @(negedge clk) if (cpu_en === 1'b1) got_q.push_back(32'(cyc));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // The level flips once the last DEB tick samples all disagree with it.
  // Returns 1 when the flip is a rising edge.
  function automatic bit model_sample(input bit b);
    bit all_diff;
    samp_q.push_back(b);
    if (samp_q.size() > DEB) void'(samp_q.pop_front());
    if (samp_q.size() == DEB) begin
      all_diff = 1'b1;
      foreach (samp_q[k]) if (samp_q[k] == m_level) all_diff = 1'b0;
      if (all_diff) begin
        m_level = ~m_level;
        samp_q.delete();
        return m_level;
      end
    end
    return 1'b0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n);
    rst = 1'b1; halt_req = 1'b0; slow_clk = 1'b0;
    step_cycles(n);
    check("rst_cpu_en", 64'(cpu_en), 64'(0));
    check("rst_mode", 64'(mode), 64'(M_STEP));
    check("rst_halted", 64'(halted), 64'(0));
    check("rst_cnt", 64'(cycle_cnt), 64'(0));
    rst = 1'b0;
    m_mode = M_STEP; m_level = 1'b0; samp_q.delete(); exp_total = 0;
    got_q.delete(); exp_q.delete();
    step_cycles(4);
    if (run_sw) m_mode = M_RUN;
  endtask

  // One slow_clk period. btn_next is applied at the falling edge, far from
  // any debounce sample point. halt_at raises halt_req in the cycle before
  // the enable for this tick would be registered.
  task automatic slow_period(input bit btn_next, input bit halt_at);
    int hi, lo, n, e;
    bit rise, hit;
    hi = $urandom_range(4, 8);
    lo = $urandom_range(4, 8);
    slow_clk = 1'b1;
    n = cyc + 1;            // first clk edge that samples slow_clk high
    e = 0; hit = 1'b0;
    rise = model_sample(step_btn);
    if (m_mode == M_RUN) e = n + 3;
    else if (m_mode == M_STEP && rise) e = n + 4;
    if (halt_at && m_mode != M_HALT) begin
      if (e == 0) e = n + 3;
      m_mode = M_HALT; hit = 1'b1;
    end else if (e != 0) begin
      exp_q.push_back(32'(e)); exp_total++;
    end
    for (int i = 1; i <= hi + lo; i++) begin
      @(negedge clk);
      halt_req = hit && (cyc == e - 1);
      if (hit && cyc == e) begin
        check("halt_cpu_en", 64'(cpu_en), 64'(0));
        check("halt_mode", 64'(mode), 64'(M_HALT));
        check("halt_halted", 64'(halted), 64'(1));
      end
      if (i == hi) begin slow_clk = 1'b0; step_btn = btn_next; end
    end
    check("per_mode", 64'(mode), 64'(m_mode));
    check("per_halted", 64'(halted), 64'(m_mode == M_HALT));
    check("per_cnt", 64'(cycle_cnt), 64'(exp_total));
    check("per_sat_cnt", 64'(cycle_cnt_s), 64'(exp_total > 7 ? 7 : exp_total));
  endtask

  task automatic compare_pulses(input string tag);
    step_cycles(6);
    check({tag, "_npulse"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_pulse_cyc"}, 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
    got_q.delete(); exp_q.delete();
  endtask

  task automatic press(input int hold);
    step_btn = 1'b1; step_cycles(4);
    repeat (hold - 1) slow_period(1'b1, 1'b0);
    slow_period(1'b0, 1'b0);
    repeat (hold) slow_period(1'b0, 1'b0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit b;
    bit seq[$];
    int g;
    rst = 1'b1; slow_clk = 1'b0; run_sw = 1'b0; step_btn = 1'b0; halt_req = 1'b0;
    step_cycles(1);

    // Reset, then RUN with 5 slow edges
    run_sw = 1'b1;
    do_reset(2);
    check("run_mode_entry", 64'(mode), 64'(M_RUN));
    repeat (5) slow_period(1'b0, 1'b0);
    compare_pulses("run");
    check("run_cnt5", 64'(cycle_cnt), 64'(5));

    // STEP debounce: a short glitch, then a long press, then a release
    run_sw = 1'b0;
    do_reset(2);
    g = $urandom_range(1, DEB - 1);
    seq.delete();
    repeat (g) seq.push_back(1'b1);
    seq.push_back(1'b0);
    repeat (DEB + 2) seq.push_back(1'b1);
    repeat (DEB + 2) seq.push_back(1'b0);
    step_btn = seq[0]; step_cycles(4);
    for (int i = 0; i < seq.size(); i++)
      slow_period((i + 1 < seq.size()) ? seq[i + 1] : 1'b0, 1'b0);
    compare_pulses("deb");
    check("deb_cnt1", 64'(cycle_cnt), 64'(1));

    // Random button activity in STEP
    b = 1'b0;
    repeat (30) begin
      if ($urandom_range(0, 3) == 0) b = ~b;
      slow_period(b, 1'b0);
    end
    slow_period(1'b0, 1'b0);
    compare_pulses("step_rand");

    // Halt priority, then 10 ticks with random presses while halted
    run_sw = 1'b1; step_btn = 1'b0;
    do_reset(2);
    repeat (3) slow_period(1'b0, 1'b0);
    slow_period(1'b0, 1'b1);
    b = 1'b0;
    repeat (10) begin
      if ($urandom_range(0, 2) == 0) b = ~b;
      slow_period(b, 1'b0);
    end
    compare_pulses("halt");
    check("halt_cnt_frozen", 64'(cycle_cnt), 64'(3));

    // Reset from HALT, then one press in STEP
    step_btn = 1'b0; run_sw = 1'b0; step_cycles(4);
    do_reset(1);
    press(DEB + 1);
    compare_pulses("post_halt");
    check("post_halt_cnt", 64'(cycle_cnt), 64'(1));

    // Mode switch: a press made in RUN is not replayed in STEP
    run_sw = 1'b1;
    do_reset(2);
    repeat (2) slow_period(1'b0, 1'b0);
    step_btn = 1'b1; step_cycles(4);
    repeat (DEB + 1) slow_period(1'b1, 1'b0);
    run_sw = 1'b0;
    step_cycles(3);
    check("switch_mode_step", 64'(mode), 64'(M_STEP));
    step_cycles(1);
    m_mode = M_STEP;
    repeat (3) slow_period(1'b1, 1'b0);
    repeat (DEB + 1) slow_period(1'b0, 1'b0);
    compare_pulses("switch");
    check("switch_cnt", 64'(cycle_cnt), 64'(DEB + 3));

    // Random run_sw and button activity
    b = 1'b0;
    repeat (40) begin
      if ($urandom_range(0, 4) == 0) begin
        run_sw = ~run_sw; step_cycles(4);
        m_mode = run_sw ? M_RUN : M_STEP;
      end
      if ($urandom_range(0, 3) == 0) b = ~b;
      slow_period(b, 1'b0);
    end
    compare_pulses("mix_rand");

    // Saturation of the 3-bit counter
    run_sw = 1'b1; step_btn = 1'b0;
    do_reset(2);
    repeat (10) slow_period(1'b0, 1'b0);
    compare_pulses("sat");
    check("sat_cnt_hold7", 64'(cycle_cnt_s), 64'(7));
    check("sat_wide_cnt10", 64'(cycle_cnt), 64'(10));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
